bram_to_coeff: RTL and testbench

BRAM_TO_COEFF -- requirements
Module: bram_to_coeff

---
 rtl/bram_to_coeff.sv | 156 +++++++++++++++
 tb/tb_bram_to_coeff.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bram_to_coeff.sv
// bram_to_coeff: on each vs_i rising edge, reads a 5x5 kernel from a
// synchronous-read coefficient BRAM into shadow registers. Once all 25 words
// are in, it commits them to the coefficient outputs in a single cycle and
// pulses en_d to mark the new set.
module bram_to_coeff #(
  parameter int NUM_COEFF = 25,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int COEFF_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vs_i,
  output logic [ADDR_W-1:0]         filter_coeff_addr,
  input  logic [DATA_W-1:0]         filter_coeff_data,
  output logic signed [COEFF_W-1:0] coeff00, coeff01, coeff02, coeff03, coeff04,
  output logic signed [COEFF_W-1:0] coeff10, coeff11, coeff12, coeff13, coeff14,
  output logic signed [COEFF_W-1:0] coeff20, coeff21, coeff22, coeff23, coeff24,
  output logic signed [COEFF_W-1:0] coeff30, coeff31, coeff32, coeff33, coeff34,
  output logic signed [COEFF_W-1:0] coeff40, coeff41, coeff42, coeff43, coeff44,
  output logic                      en_d
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READ   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_COEFF - 1);

  logic [1:0]                state_q, state_d;
  logic                      vs_q;
  logic                      rise_s;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      cap_valid_q, cap_valid_d;
  logic [ADDR_W-1:0]         cap_idx_q, cap_idx_d;
  logic                      en_pulse_q, en_pulse_d;
  logic signed [COEFF_W-1:0] shadow_q [NUM_COEFF];
  logic signed [COEFF_W-1:0] shadow_d [NUM_COEFF];
  logic signed [COEFF_W-1:0] coeff_q  [NUM_COEFF];
  logic signed [COEFF_W-1:0] coeff_d  [NUM_COEFF];
  logic                      unused_s;

  // Only the low COEFF_W bits of each BRAM word carry the coefficient.
  assign unused_s = ^filter_coeff_data[DATA_W-1:COEFF_W];

  assign rise_s            = vs_i & ~vs_q;
  assign filter_coeff_addr = addr_q;
  assign en_d              = en_pulse_q;

  // FSM next state, address sequencing and capture bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = {ADDR_W{1'b0}};
    cap_valid_d = 1'b0;
    cap_idx_d   = addr_q;
    en_pulse_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        // Each address issued now returns data next cycle, so mark it for capture.
        cap_valid_d = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = COMMIT;
          addr_d  = {ADDR_W{1'b0}};
        end else begin
          state_d = READ;
          addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      COMMIT: begin
        // The last word arrives in this cycle; it is bypassed into the commit.
        en_pulse_d = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shadow capture of returning BRAM data, and the single-cycle commit to the outputs.
  always_comb begin
    for (int i = 0; i < NUM_COEFF; i++) begin
      if (cap_valid_q && (cap_idx_q == ADDR_W'(i))) begin
        shadow_d[i] = filter_coeff_data[COEFF_W-1:0];
      end else begin
        shadow_d[i] = shadow_q[i];
      end
      if (state_q == COMMIT) begin
        coeff_d[i] = shadow_d[i];
      end else begin
        coeff_d[i] = coeff_q[i];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vs_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      cap_valid_q <= 1'b0;
      cap_idx_q   <= {ADDR_W{1'b0}};
      en_pulse_q  <= 1'b0;
      for (int i = 0; i < NUM_COEFF; i++) begin
        shadow_q[i] <= {COEFF_W{1'b0}};
        coeff_q[i]  <= {COEFF_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      vs_q        <= vs_i;
      addr_q      <= addr_d;
      cap_valid_q <= cap_valid_d;
      cap_idx_q   <= cap_idx_d;
      en_pulse_q  <= en_pulse_d;
      for (int i = 0; i < NUM_COEFF; i++) begin
        shadow_q[i] <= shadow_d[i];
        coeff_q[i]  <= coeff_d[i];
      end
    end
  end

  assign coeff00 = coeff_q[0];
  assign coeff01 = coeff_q[1];
  assign coeff02 = coeff_q[2];
  assign coeff03 = coeff_q[3];
  assign coeff04 = coeff_q[4];
  assign coeff10 = coeff_q[5];
  assign coeff11 = coeff_q[6];
  assign coeff12 = coeff_q[7];
  assign coeff13 = coeff_q[8];
  assign coeff14 = coeff_q[9];
  assign coeff20 = coeff_q[10];
  assign coeff21 = coeff_q[11];
  assign coeff22 = coeff_q[12];
  assign coeff23 = coeff_q[13];
  assign coeff24 = coeff_q[14];
  assign coeff30 = coeff_q[15];
  assign coeff31 = coeff_q[16];
  assign coeff32 = coeff_q[17];
  assign coeff33 = coeff_q[18];
  assign coeff34 = coeff_q[19];
  assign coeff40 = coeff_q[20];
  assign coeff41 = coeff_q[21];
  assign coeff42 = coeff_q[22];
  assign coeff43 = coeff_q[23];
  assign coeff44 = coeff_q[24];

endmodule

// File: tb/tb_bram_to_coeff.sv
// Self-checking bench for bram_to_coeff. It models the synchronous-read BRAM,
// pushes the expected kernel when a load is requested, and pops/compares that
// kernel when en_d fires. Between pulses, outputs must hold their last value.
module tb_bram_to_coeff;

  typedef logic [24:0][15:0] set_t;

  logic              clk;
  logic              rst;
  logic              vs_i;
  logic [5:0]        addr;
  logic [31:0]       rdata;
  logic              en_d;
  logic signed [15:0] c [25];

  logic [31:0] mem [64];
  set_t        exp_q [$];
  set_t        held;
  int          errors;
  int          checks;
  int          en_cnt;

  bram_to_coeff dut (
    .clk(clk), .rst(rst), .vs_i(vs_i),
    .filter_coeff_addr(addr), .filter_coeff_data(rdata),
    .coeff00(c[0]),  .coeff01(c[1]),  .coeff02(c[2]),  .coeff03(c[3]),  .coeff04(c[4]),
    .coeff10(c[5]),  .coeff11(c[6]),  .coeff12(c[7]),  .coeff13(c[8]),  .coeff14(c[9]),
    .coeff20(c[10]), .coeff21(c[11]), .coeff22(c[12]), .coeff23(c[13]), .coeff24(c[14]),
    .coeff30(c[15]), .coeff31(c[16]), .coeff32(c[17]), .coeff33(c[18]), .coeff34(c[19]),
    .coeff40(c[20]), .coeff41(c[21]), .coeff42(c[22]), .coeff43(c[23]), .coeff44(c[24]),
    .en_d(en_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read BRAM model: data appears one clock after the address.
  always @(posedge clk) rdata <= mem[addr];

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic set_t snapshot();
    set_t s;
    for (int k = 0; k < 25; k++) s[k] = mem[k][15:0];
    return s;
  endfunction

  // Output monitor: compare every coefficient every cycle against the held model.
  initial begin
    held   = '0;
    en_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        held = '0;
      end else if (en_d) begin
        en_cnt++;
        if (exp_q.size() == 0) begin
          chk("en_unexpected", 1, 0);
        end else begin
          held = exp_q.pop_front();
        end
      end
      for (int k = 0; k < 25; k++) begin
        chk($sformatf("coeff%0d%0d", k / 5, k % 5), longint'(c[k]), longint'($signed(held[k])));
      end
    end
  end

  // mode 0: plain pulse, 1: second pulse during READ, 2: reset at T+10, 3: vs held high.
  task automatic do_load(input int mode);
    int en_before;
    en_before = en_cnt;
    @(negedge clk);
    vs_i = 1'b1;
    exp_q.push_back(snapshot());
    for (int k = 0; k <= 27; k++) begin
      @(negedge clk);
      if (mode == 2 && k == 10) begin
        rst = 1'b1;
        vs_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_addr", addr, 0);
        chk("rst_en", en_d, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_addr", addr, 0);
        chk("rst_no_en", en_cnt - en_before, 0);
        return;
      end
      chk($sformatf("addr_T%0d", k), addr, (k <= 24) ? k : 0);
      chk($sformatf("en_T%0d", k), en_d, (k == 26) ? 1 : 0);
      if (mode != 3 && k == 0) vs_i = 1'b0;
      if (mode == 1 && k == 4) vs_i = 1'b1;
      if (mode == 1 && k == 6) vs_i = 1'b0;
    end
    if (mode == 3) begin
      repeat (72) @(negedge clk);
      vs_i = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("en_once", en_cnt - en_before, 1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    vs_i   = 1'b0;
    for (int k = 0; k < 64; k++) mem[k] = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_addr", addr, 0);
    chk("reset_en", en_d, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_addr", addr, 0);

    // Ramp kernel: word k = k-12.
    for (int k = 0; k < 64; k++) mem[k] = 32'(k - 12);
    do_load(0);
    chk("ramp_c00", longint'(c[0]), -12);
    chk("ramp_c22", longint'(c[12]), 0);
    chk("ramp_c44", longint'(c[24]), 12);

    // Upper half of the BRAM word must be ignored.
    for (int k = 0; k < 64; k++) mem[k] = 32'hABCD_0005;
    do_load(0);
    for (int k = 0; k < 25; k++) chk("upper_ign", longint'(c[k]), 5);

    // Second pulse during READ is ignored.
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    do_load(1);

    // Set A then set B: the monitor checks outputs hold A until en_d.
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    do_load(0);

    // Reset mid-READ, then a clean full load.
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    do_load(2);
    for (int k = 0; k < 25; k++) chk("rst_coeff", longint'(c[k]), 0);
    do_load(0);

    // vs held high for 100 cycles triggers one load.
    for (int k = 0; k < 64; k++) mem[k] = 32'(k * 3 - 40);
    do_load(3);
    chk("held_c44", longint'(c[24]), 32);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
